// File: rtl/instrn_feeder_if.sv
// Loader and fetch-side signal bundle for instrn_feeder.
// master = loader/core side, slave = the feeder itself.
interface instrn_feeder_if #(
    parameter int AW = 4
) ();
    logic          Load_Valid;
    logic [31:0]   Load_Data;
    logic          Load_Ready;
    logic          Flush;
    logic          Rd_Instr;
    logic [31:0]   Instrn;
    logic          Instrn_Valid;
    logic [AW:0]   Fill_Level;
    logic [15:0]   Issue_Count;
    logic          Underflow;

    modport master (
        output Load_Valid, Load_Data, Flush, Rd_Instr,
        input  Load_Ready, Instrn, Instrn_Valid, Fill_Level, Issue_Count, Underflow
    );

    modport slave (
        input  Load_Valid, Load_Data, Flush, Rd_Instr,
        output Load_Ready, Instrn, Instrn_Valid, Fill_Level, Issue_Count, Underflow
    );
endinterface

// File: rtl/instrn_feeder.sv
// Instruction FIFO plus registered presentation stage feeding the core's Instrn pins.
// Holds up to DEPTH+1 words: DEPTH in the FIFO and one on Instrn.
module instrn_feeder #(
    parameter int          DEPTH      = 16,
    parameter int          AW         = 4,
    parameter logic [31:0] NOP_INSTRN = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    instrn_feeder_if.slave  bus
);
    typedef enum logic {EMPTY, PRESENTING} state_t;

    localparam logic [AW:0]   FULL_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_C   = (AW+1)'(1);
    localparam logic [AW-1:0] PSTEP_C = AW'(1);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   instrn_q, instrn_d;
    state_t        state_q, state_d;
    logic [15:0]   issue_q, issue_d;
    logic          underflow_q, underflow_d;

    logic load_ready, accept, take, fifo_empty, pop, bypass, push, presenting;

    always_comb begin
        presenting = (state_q == PRESENTING);
        load_ready = !reset && !bus.Flush && (count_q < FULL_C);
        accept     = bus.Load_Valid && load_ready;
        take       = !presenting || bus.Rd_Instr;
        fifo_empty = (count_q == '0);
        pop        = take && !fifo_empty;
        // An empty FIFO lets the incoming word skip straight to Instrn.
        bypass     = take && fifo_empty && accept;
        push       = accept && !bypass;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        instrn_d    = instrn_q;
        state_d     = state_q;
        issue_d     = issue_q;
        underflow_d = underflow_q;

        // Consumption and underflow are recorded even on a flush cycle.
        if (bus.Rd_Instr && presenting) issue_d = issue_q + 16'd1;
        if (bus.Rd_Instr && !presenting) underflow_d = 1'b1;

        if (bus.Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            instrn_d = NOP_INSTRN;
            state_d  = EMPTY;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PSTEP_C;
            if (pop)  rd_ptr_d = rd_ptr_q + PSTEP_C;
            if (push && !pop)      count_d = count_q + ONE_C;
            else if (pop && !push) count_d = count_q - ONE_C;

            if (take) begin
                if (!fifo_empty) begin
                    instrn_d = mem_q[rd_ptr_q];
                    state_d  = PRESENTING;
                end else if (accept) begin
                    instrn_d = bus.Load_Data;
                    state_d  = PRESENTING;
                end else begin
                    instrn_d = NOP_INSTRN;
                    state_d  = EMPTY;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            instrn_q    <= NOP_INSTRN;
            state_q     <= EMPTY;
            issue_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            instrn_q    <= instrn_d;
            state_q     <= state_d;
            issue_q     <= issue_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage needs no reset; push is already gated off by reset and flush.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.Load_Data;
    end

    assign bus.Load_Ready   = load_ready;
    assign bus.Instrn       = instrn_q;
    assign bus.Instrn_Valid = presenting;
    assign bus.Fill_Level   = count_q;
    assign bus.Issue_Count  = issue_q;
    assign bus.Underflow    = underflow_q;
endmodule

// File: tb/tb_instrn_feeder.sv
// Scoreboard bench for instrn_feeder: accepted words queue up, consumed words retire from the front.
module tb_instrn_feeder;
    logic clk = 1'b0;
    logic reset;

    instrn_feeder_if #(.AW(4)) bus ();

    instrn_feeder #(.DEPTH(16), .AW(4), .NOP_INSTRN(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Words held by the block: sb[0] is the presented word, the rest sit in the FIFO.
    logic [31:0] sb [$];
    logic [15:0] m_issue;
    logic        m_uf;

    function automatic logic [31:0] e_instr();
        return (sb.size() != 0) ? sb[0] : 32'h0;
    endfunction

    function automatic logic e_valid();
        return sb.size() != 0;
    endfunction

    function automatic logic [4:0] e_fill();
        return (sb.size() > 1) ? 5'(sb.size() - 1) : 5'd0;
    endfunction

    task automatic drive(input logic lv, input logic [31:0] d, input logic rd, input logic fl);
        logic rdy;
        @(negedge clk);
        bus.Load_Valid = lv;
        bus.Load_Data  = d;
        bus.Rd_Instr   = rd;
        bus.Flush      = fl;
        rdy = !fl && (e_fill() < 5'd16);
        @(posedge clk);
        if (rd && e_valid()) begin
            void'(sb.pop_front());
            m_issue = m_issue + 16'd1;
        end
        if (rd && !e_valid()) m_uf = 1'b1;
        if (fl) sb.delete();
        else if (lv && rdy) sb.push_back(d);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.Load_Valid = 1'b1;
        bus.Load_Data  = 32'hDEAD_BEEF;
        bus.Rd_Instr   = 1'b0;
        bus.Flush      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        bus.Load_Valid = 1'b0;
        sb.delete();
        m_issue = '0;
        m_uf    = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.Load_Valid = 1'b1;
        bus.Load_Data  = 32'hDEAD_BEEF;
        bus.Rd_Instr   = 1'b0;
        bus.Flush      = 1'b0;
        @(posedge clk); #1;
        total++;
        if (bus.Load_Ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", bus.Load_Ready); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        bus.Load_Valid = 1'b0;
        sb.delete(); m_issue = '0; m_uf = 1'b0;
        #1;
        total++;
        if (bus.Instrn !== 32'h0) begin bad++; $display("FAIL reset_instrn: got %h want 0", bus.Instrn); end
        total++;
        if (bus.Instrn_Valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.Instrn_Valid); end
        total++;
        if (bus.Fill_Level !== 5'd0) begin bad++; $display("FAIL reset_fill: got %0d want 0", bus.Fill_Level); end
        total++;
        if (bus.Issue_Count !== 16'd0 || bus.Underflow !== 1'b0) begin
            bad++; $display("FAIL reset_counters: got issue=%0d uf=%b want 0/0", bus.Issue_Count, bus.Underflow);
        end
        total++;
        if (bus.Load_Ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready: got %b want 1", bus.Load_Ready); end
    endtask

    task automatic test_bypass();
        do_reset();
        drive(1'b1, 32'h1234_5678, 1'b0, 1'b0);
        total++;
        if (bus.Instrn !== 32'h1234_5678 || bus.Instrn_Valid !== 1'b1) begin
            bad++; $display("FAIL bypass_instrn: got %h/%b want 12345678/1", bus.Instrn, bus.Instrn_Valid);
        end
        total++;
        if (bus.Fill_Level !== 5'd0) begin bad++; $display("FAIL bypass_fill: got %0d want 0", bus.Fill_Level); end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        total++;
        if (bus.Instrn !== 32'h1234_5678) begin bad++; $display("FAIL bypass_hold: got %h want 12345678", bus.Instrn); end
    endtask

    task automatic test_fill_full();
        do_reset();
        for (int i = 0; i < 17; i++) drive(1'b1, 32'(i), 1'b0, 1'b0);
        total++;
        if (bus.Instrn !== 32'h0 || bus.Instrn_Valid !== 1'b1) begin
            bad++; $display("FAIL full_instrn: got %h/%b want 0/1", bus.Instrn, bus.Instrn_Valid);
        end
        total++;
        if (bus.Fill_Level !== 5'd16) begin bad++; $display("FAIL full_fill: got %0d want 16", bus.Fill_Level); end
        total++;
        if (bus.Load_Ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b want 0", bus.Load_Ready); end
        drive(1'b1, 32'h99, 1'b0, 1'b0);
        total++;
        if (bus.Fill_Level !== 5'd16 || sb.size() != 17) begin
            bad++; $display("FAIL full_reject: got fill=%0d want 16", bus.Fill_Level);
        end
        for (int i = 1; i <= 17; i++) begin
            logic [31:0] want;
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            want = (i <= 16) ? 32'(i) : 32'h0;
            total++;
            if (bus.Instrn !== want || bus.Instrn !== e_instr()) begin
                bad++; $display("FAIL drain_order[%0d]: got %h want %h", i, bus.Instrn, want);
            end
            if (i == 1) begin
                total++;
                if (bus.Load_Ready !== 1'b1) begin bad++; $display("FAIL ready_after_pop: got %b want 1", bus.Load_Ready); end
            end
        end
        total++;
        if (bus.Instrn_Valid !== 1'b0) begin bad++; $display("FAIL drain_valid: got %b want 0", bus.Instrn_Valid); end
        total++;
        if (bus.Issue_Count !== 16'd17) begin bad++; $display("FAIL drain_issue: got %0d want 17", bus.Issue_Count); end
    endtask

    task automatic test_push_pop();
        do_reset();
        for (int i = 0; i < 6; i++) drive(1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
        total++;
        if (bus.Fill_Level !== 5'd5) begin bad++; $display("FAIL pp_prefill: got %0d want 5", bus.Fill_Level); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'hB000_0000 + 32'(i), 1'b1, 1'b0);
            total++;
            if (bus.Fill_Level !== 5'd5) begin bad++; $display("FAIL pp_fill[%0d]: got %0d want 5", i, bus.Fill_Level); end
            total++;
            if (bus.Instrn !== e_instr()) begin bad++; $display("FAIL pp_instrn[%0d]: got %h want %h", i, bus.Instrn, e_instr()); end
        end
        while (sb.size() != 0) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            total++;
            if (bus.Instrn !== e_instr() || bus.Instrn_Valid !== e_valid()) begin
                bad++; $display("FAIL pp_drain: got %h/%b want %h/%b", bus.Instrn, bus.Instrn_Valid, e_instr(), e_valid());
            end
        end
    endtask

    task automatic test_underflow();
        do_reset();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        total++;
        if (bus.Underflow !== 1'b1 || bus.Issue_Count !== 16'd0) begin
            bad++; $display("FAIL uf_set: got uf=%b issue=%0d want 1/0", bus.Underflow, bus.Issue_Count);
        end
        drive(1'b1, 32'h5555_AAAA, 1'b0, 1'b0);
        total++;
        if (bus.Underflow !== 1'b1 || bus.Instrn !== 32'h5555_AAAA) begin
            bad++; $display("FAIL uf_sticky: got uf=%b instrn=%h want 1/5555aaaa", bus.Underflow, bus.Instrn);
        end
        do_reset();
        #1;
        total++;
        if (bus.Underflow !== 1'b0) begin bad++; $display("FAIL uf_clear: got %b want 0", bus.Underflow); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, 32'hC000_0000 + 32'(i), 1'b0, 1'b0);
        total++;
        if (bus.Fill_Level !== 5'd3) begin bad++; $display("FAIL fl_prefill: got %0d want 3", bus.Fill_Level); end
        drive(1'b1, 32'hEEEE_EEEE, 1'b1, 1'b1);
        total++;
        if (bus.Issue_Count !== 16'd1) begin bad++; $display("FAIL fl_issue: got %0d want 1", bus.Issue_Count); end
        total++;
        if (bus.Fill_Level !== 5'd0 || bus.Instrn_Valid !== 1'b0 || bus.Instrn !== 32'h0) begin
            bad++; $display("FAIL fl_state: got fill=%0d v=%b instrn=%h want 0/0/0", bus.Fill_Level, bus.Instrn_Valid, bus.Instrn);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        total++;
        if (bus.Instrn_Valid !== 1'b0 || bus.Fill_Level !== 5'd0) begin
            bad++; $display("FAIL fl_dropped: got v=%b fill=%0d want 0/0", bus.Instrn_Valid, bus.Fill_Level);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            logic lv, rd, fl;
            lv = 1'($urandom_range(0, 3) != 0);
            rd = 1'($urandom_range(0, 2) == 0);
            fl = 1'($urandom_range(0, 50) == 0);
            drive(lv, $urandom, rd, fl);
            total++;
            if (bus.Instrn !== e_instr() || bus.Instrn_Valid !== e_valid() || bus.Fill_Level !== e_fill()) begin
                bad++; $display("FAIL b2b_data[%0d]: got %h/%b/%0d want %h/%b/%0d", c, bus.Instrn, bus.Instrn_Valid,
                                 bus.Fill_Level, e_instr(), e_valid(), e_fill());
            end
            total++;
            if (bus.Issue_Count !== m_issue || bus.Underflow !== m_uf) begin
                bad++; $display("FAIL b2b_cnt[%0d]: got %0d/%b want %0d/%b", c, bus.Issue_Count, bus.Underflow, m_issue, m_uf);
            end
            total++;
            if (bus.Load_Ready !== (!fl && (e_fill() < 5'd16))) begin
                bad++; $display("FAIL b2b_ready[%0d]: got %b want %b", c, bus.Load_Ready, !fl && (e_fill() < 5'd16));
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.Load_Valid = 1'b0;
        bus.Load_Data  = '0;
        bus.Rd_Instr   = 1'b0;
        bus.Flush      = 1'b0;
        m_issue = '0;
        m_uf    = 1'b0;
        test_reset();
        test_bypass();
        test_fill_full();
        test_push_pop();
        test_underflow();
        test_flush();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: run did not complete");
        $fatal(1);
    end
endmodule

// File: doc/instrn_feeder.md
# instrn_feeder

Instruction-side responder for the RISC core's fetch handshake. It buffers 32-bit instruction words loaded by a host or testbench loader into a DEPTH-entry FIFO. It presents the head word on `Instrn` and advances to the next word each cycle the core asserts `Rd_Instr`. It sits between the program loader and the core's `Instrn`/`Rd_Instr` pins, and also reports fill level, issue count and fetch underflow.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, minimum 2
- `AW`, 4, log2(DEPTH)
- `NOP_INSTRN`, 32'h0000_0000, word driven on `Instrn` when no valid instruction is held
- `clk`  in  1  single clock; all state changes on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `Load_Valid`  in  1  loader offers `Load_Data` this cycle
- `Load_Data`  in  32  instruction word from the loader
- `Load_Ready`  out  1  FIFO can accept a word this cycle
- `Flush`  in  1  discard all buffered and presented instructions
- `Rd_Instr`  in  1  core consumes the presented instruction (core's `Latch_Instr`)
- `Instrn`  out  32  registered presented instruction, to core `Instrn`
- `Instrn_Valid`  out  1  `Instrn` holds a real instruction
- `Fill_Level`  out  AW+1  FIFO occupancy, 0..DEPTH; excludes the presented word
- `Issue_Count`  out  16  instructions consumed since reset
- `Underflow`  out  1  sticky: `Rd_Instr` seen while `Instrn_Valid`=0

## Operation
- **Storage.**
  - FIFO: DEPTH x 32 with write pointer, read pointer and count; pointers wrap modulo DEPTH.
  - Output stage: registers `Instrn` and `Instrn_Valid`.
- **Load accept.** A word is accepted when `Load_Valid` && `Load_Ready`.
  - `Load_Ready` = !`Flush` && (`Fill_Level` < DEPTH).
  - `Load_Ready` depends only on registered count and `Flush`; there is no path from `Rd_Instr` to it.
- **Output refill condition.** The output stage "takes" when (!`Instrn_Valid` || `Rd_Instr`). When it takes:
  - FIFO non-empty: load the FIFO head, pop it, set `Instrn_Valid`=1.
  - FIFO empty and load accepted this cycle: bypass `Load_Data` directly into `Instrn` with `Instrn_Valid`=1; the FIFO is not written.
  - Otherwise: `Instrn`=NOP_INSTRN, `Instrn_Valid`=0.
- **Load when not bypassed.** An accepted word is written to the FIFO at the write pointer.
- **Same-cycle push and pop.** Count is unchanged.
- **Consume.** `Rd_Instr` && `Instrn_Valid` increments `Issue_Count`, which wraps FFFF to 0000.
- **Underflow.** `Rd_Instr` && !`Instrn_Valid` sets `Underflow`. It is cleared only by `reset`, and `Issue_Count` is unchanged.
- **Flush.** Highest priority after reset.
  - Pointers and count go to 0; `Instrn`=NOP_INSTRN; `Instrn_Valid`=0.
  - Any load that cycle is dropped (`Load_Ready`=0).
  - `Rd_Instr` that cycle counts normally if `Instrn_Valid` was 1.
  - `Issue_Count` and `Underflow` are retained.
- **Control.** Implicit two-state: EMPTY (`Instrn_Valid`=0) and PRESENTING (`Instrn_Valid`=1).
  - EMPTY to PRESENTING: FIFO non-empty or bypass load.
  - PRESENTING to EMPTY: `Rd_Instr` with FIFO empty and no load, or `Flush`.

## Timing
- **Reset** (synchronous, on the edge where `reset`=1):
  - `Instrn`=NOP_INSTRN, `Instrn_Valid`=0, `Fill_Level`=0, `Issue_Count`=0, `Underflow`=0.
  - Pointers cleared; `Load_Ready`=0 while `reset` is high.
  - Reset mid-stream discards all contents.
- **Load to present.** A word accepted at edge N into an empty block appears on `Instrn` with `Instrn_Valid`=1 after edge N (1-cycle latency).
- **Throughput.** With `Rd_Instr` held high and the FIFO non-empty, a new instruction is presented every cycle, in load order.
- **`Instrn` hold.** `Instrn` is stable while `Instrn_Valid`=1 and `Rd_Instr`=0.
- **Full.** `Fill_Level`=DEPTH holds `Load_Ready`=0 even if `Rd_Instr`=1 that cycle. `Load_Ready` returns to 1 the cycle after the pop.
- **Total capacity.** DEPTH+1 words: the FIFO plus the presented word.
- **Outputs.** All outputs are registered except `Load_Ready`, which is combinational from registered count and the `Flush` input.

## Test plan
- **Reset values:** assert `reset` 2 cycles with `Load_Valid`=1 -> `Instrn`=0, `Instrn_Valid`=0, `Fill_Level`=0, `Load_Ready`=0; nothing is accepted.
- **Bypass:** load 32'h1234_5678 into the empty block at edge N, `Rd_Instr`=0 -> after N, `Instrn`=32'h1234_5678, `Instrn_Valid`=1, `Fill_Level`=0.
- **Fill to full:** load 17 words 0..16 with `Rd_Instr`=0 -> `Instrn`=0, `Fill_Level`=16, `Load_Ready`=0. A further `Load_Valid` is not accepted. Hold `Rd_Instr`=1 for 17 cycles -> `Instrn` runs 1..16 then NOP, `Issue_Count`=17.
- **Simultaneous push/pop:** at `Fill_Level`=5, load and `Rd_Instr` in the same cycle -> `Fill_Level` stays 5, order preserved.
- **Underflow:** `Rd_Instr`=1 while empty -> `Underflow`=1 next cycle, `Issue_Count` unchanged. A later load leaves `Underflow`=1 until `reset`.
- **Flush:** with 3 queued plus 1 presented, assert `Flush` together with `Load_Valid` and `Rd_Instr` -> `Issue_Count`+1, `Fill_Level`=0, `Instrn_Valid`=0, `Instrn`=NOP, and the load is dropped.
